// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 Booth multiply path: digit encoding,
// accumulator FSM states and the default digit count.
package mul_pkg;

  localparam int unsigned DIGITS = 16;

  localparam int unsigned NEG_BIT = 2;
  localparam int unsigned MAG_MSB = 1;
  localparam int unsigned MAG_LSB = 0;

  localparam logic [1:0] DIG_ZERO = 2'd0;
  localparam logic [1:0] DIG_ONE  = 2'd1;
  localparam logic [1:0] DIG_TWO  = 2'd2;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth partial product: selects 0/M/2M from the digit,
// applies the sign, and aligns it to digit position count_i.
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CntW  = 4
) (
  input  logic [WIDTH-1:0]   m_reg_i,
  input  logic [2:0]         digit_i,
  input  logic [CntW-1:0]    count_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] m_ext;
  logic [2*WIDTH-1:0] sel;
  logic [2*WIDTH-1:0] signed_sel;

  always_comb begin
    m_ext = {{WIDTH{m_reg_i[WIDTH-1]}}, m_reg_i};
    unique case (digit_i[MAG_MSB:MAG_LSB])
      DIG_ZERO: sel = '0;
      DIG_ONE:  sel = m_ext;
      DIG_TWO:  sel = m_ext << 1;
      default:  sel = '0;  // mag 3 is illegal and contributes nothing
    endcase
    signed_sel = digit_i[NEG_BIT] ? -sel : sel;
    pp_o       = signed_sel << {count_i, 1'b0};
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Sequential radix-4 Booth accumulator: sums one partial product per accepted
// digit (LSB digit first) and publishes the 2*WIDTH product with a done pulse.
module booth_pp_accumulator
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DIGITS
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               digit_valid,
  input  logic [2:0]         digit,
  output logic               digit_ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned NumDigits = WIDTH / 2;
  localparam int unsigned CntW      = $clog2(NumDigits);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] acc_sum;

  booth_pp_gen #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_pp_gen (
    .m_reg_i (m_q),
    .digit_i (digit),
    .count_i (count_q),
    .pp_o    (pp)
  );

  assign acc_sum = acc_q + pp;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    product_d   = product_q;
    m_d         = m_q;
    count_d     = count_q;
    digit_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          m_d     = multiplicand;
          acc_d   = '0;
          count_d = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        busy        = 1'b1;
        digit_ready = 1'b1;
        if (digit_valid) begin
          acc_d   = acc_sum;
          count_d = count_q + 1'b1;
          // Product is registered on entry to StDone so it is visible with done.
          if (count_q == CntW'(NumDigits - 1)) begin
            product_d = acc_sum;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      product_q <= '0;
      m_q       <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      m_q       <= m_d;
      count_q   <= count_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Self-checking bench for booth_pp_accumulator: directed cases plus random
// digit streams compared against an arithmetic sum-of-digits model.
module tb_booth_pp_accumulator;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [31:0] multiplicand;
  logic        digit_valid;
  logic [2:0]  digit;
  logic        digit_ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  booth_pp_accumulator #(
    .WIDTH (32)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .start        (start),
    .multiplicand (multiplicand),
    .digit_valid  (digit_valid),
    .digit        (digit),
    .digit_ready  (digit_ready),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks;
  int          n_errors;
  logic [2:0]  digs [16];
  int          res_cyc;
  int          res_busy;
  logic [63:0] res_prod;
  logic        res_done2;
  logic [63:0] res_prod2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_q5();
    for (int i = 0; i < 16; i++) digs[i] = 3'b000;
    digs[0] = 3'b001;
    digs[1] = 3'b001;
  endtask

  // Runs one multiply. Cycle 0 is the cycle start is presented; res_cyc is the
  // cycle in which done is observed. Stalls of st_len cycles follow the
  // st_a-th and st_b-th accepted digits. abort_after>0 resets after that digit.
  task automatic run_mul(input logic [31:0] m, input int st_a, input int st_b,
                         input int st_len, input int start_pulse, input int abort_after);
    int   cyc;
    int   idx;
    int   stall;
    logic v;
    res_cyc  = -1;
    res_busy = 0;
    res_prod = '0;
    multiplicand = m;
    start        = 1'b1;
    digit_valid  = 1'b0;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    cyc   = 1;
    idx   = 0;
    stall = 0;
    while (cyc < 100) begin
      if (done) begin
        res_cyc  = cyc;
        res_prod = product;
        break;
      end
      if (busy && digit_ready) res_busy++;
      start = (cyc == start_pulse);
      if (stall > 0) begin
        digit_valid = 1'b0;
        digit       = 3'($urandom);
        stall--;
      end else begin
        digit_valid = 1'b1;
        digit       = (idx < 16) ? digs[idx] : 3'b010;
      end
      v = digit_valid;
      @(posedge clk); #1;
      start = 1'b0;
      if (v) begin
        idx++;
        if (idx == st_a || idx == st_b) stall = st_len;
        if (idx == abort_after) begin
          clr_n = 1'b0;
          #1;
          chk("abort_product", product, 64'h0);
          chk("abort_busy", {63'h0, busy}, 64'h0);
          chk("abort_ready", {63'h0, digit_ready}, 64'h0);
          chk("abort_done", {63'h0, done}, 64'h0);
          digit_valid = 1'b0;
          @(posedge clk); #1;
          clr_n = 1'b1;
          return;
        end
      end
      cyc++;
    end
    // Done cycle: feed a bogus digit and start-free idle to confirm they are ignored.
    digit_valid = 1'b1;
    digit       = 3'b010;
    @(posedge clk); #1;
    digit_valid = 1'b0;
    res_done2   = done;
    res_prod2   = product;
  endtask

  initial begin
    int          done_seen;
    longint      mx;
    longint      expv;
    logic [31:0] rm;
    int          sa;
    int          sb;
    int          sl;
    int          sp;
    n_checks     = 0;
    n_errors     = 0;
    clr_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    digit_valid  = 1'b0;
    digit        = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_product", product, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_ready", {63'h0, digit_ready}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);

    // Start held while reset is asserted must not launch a multiply.
    start = 1'b1;
    multiplicand = 32'd3;
    @(posedge clk); #1;
    chk("start_in_reset", {63'h0, busy}, 64'h0);
    start = 1'b0;
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", {63'h0, busy}, 64'h0);

    // M=3, Q=5
    set_q5();
    run_mul(32'd3, -1, -1, 0, -1, -1);
    chk("q5_done_cycle", 64'(res_cyc), 64'd17);
    chk("q5_product", res_prod, 64'h0000_0000_0000_000F);
    chk("q5_busy_cycles", 64'(res_busy), 64'd16);
    chk("q5_done_pulse", {63'h0, res_done2}, 64'h0);
    chk("q5_product_held", res_prod2, 64'h0000_0000_0000_000F);

    // M=-1, Q=-1
    for (int i = 0; i < 16; i++) digs[i] = 3'b000;
    digs[0] = 3'b101;
    run_mul(32'hFFFF_FFFF, -1, -1, 0, -1, -1);
    chk("neg1_product", res_prod, 64'h0000_0000_0000_0001);

    // M=max positive, Q=min negative
    for (int i = 0; i < 16; i++) digs[i] = 3'b000;
    digs[15] = 3'b110;
    run_mul(32'h7FFF_FFFF, -1, -1, 0, -1, -1);
    chk("minmax_product", res_prod, 64'hC000_0000_8000_0000);

    // Stalls after digits 4 and 11
    set_q5();
    run_mul(32'd3, 4, 11, 3, -1, -1);
    chk("stall_done_cycle", 64'(res_cyc), 64'd23);
    chk("stall_product", res_prod, 64'h0000_0000_0000_000F);

    // Ignored mid-run start plus illegal digits
    set_q5();
    digs[6] = 3'b011;
    digs[9] = 3'b111;
    run_mul(32'd3, -1, -1, 0, 5, -1);
    chk("illegal_done_cycle", 64'(res_cyc), 64'd17);
    chk("illegal_product", res_prod, 64'h0000_0000_0000_000F);
    chk("illegal_done_pulse", {63'h0, res_done2}, 64'h0);

    // Reset mid-operation, then confirm no done appears
    set_q5();
    run_mul(32'h1234_5678, -1, -1, 0, -1, 7);
    done_seen = 0;
    digit_valid = 1'b1;
    digit = 3'b001;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    digit_valid = 1'b0;
    chk("abort_no_done", 64'(done_seen), 64'd0);
    run_mul(32'd3, -1, -1, 0, -1, -1);
    chk("after_abort_product", res_prod, 64'h0000_0000_0000_000F);

    // Random digit streams against M * sum(d_i * 4^i)
    for (int t = 0; t < 8; t++) begin
      rm   = $urandom;
      mx   = longint'($signed(rm));
      expv = 0;
      for (int i = 0; i < 16; i++) begin
        int nb;
        int mg;
        int val;
        nb  = int'($urandom_range(0, 1));
        mg  = int'($urandom_range(0, 3));
        digs[i] = {nb[0], mg[1:0]};
        val = (mg == 3) ? 0 : mg;
        if (nb == 1) val = -val;
        expv = expv + mx * longint'(val) * (64'sd1 <<< (2 * i));
      end
      sa = int'($urandom_range(1, 7));
      sb = int'($urandom_range(8, 15));
      sl = int'($urandom_range(0, 3));
      sp = int'($urandom_range(2, 30));
      run_mul(rm, sa, sb, sl, sp, -1);
      chk("rand_product", res_prod, 64'(expv));
      chk("rand_done_cycle", 64'(res_cyc), 64'(17 + 2 * sl));
      chk("rand_product_held", res_prod2, 64'(expv));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
